i2c_expander_write_master: RTL and testbench
============================================

Name: i2c_expander_write_master

Overview:
- Single-byte I2C write master that drives PCF8574-style 8-bit output expanders (I2CslaveWith8bitsIO_v2 instances) on the power-control bus.
- Two local requesters share the master through round-robin arbitration.
- Each transaction is: START, address+W, ACK, data byte, ACK, STOP.
- SCL and SDA are open-drain. The block only ever drives them low or releases them; read transfers are not supported.

Parameters:
CLK_DIV, 125, clk cycles per quarter SCL bit period (100 kHz at 50 MHz); legal range 2..65535
RETRIES, 2, extra attempts after a NACK (used only with I2C_WR_RETRY_EN)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
req0  in  1  requester 0 request, level; held until done0
adr0  in  7  requester 0 target 7-bit address
dat0  in  8  requester 0 data byte
done0  out  1  one-clk pulse: requester 0 transaction finished
nack0  out  1  valid with done0: 1 = a NACK terminated the transaction
req1/adr1/dat1/done1/nack1  as requester 0
busy  out  1  high from the grant cycle to the done pulse, inclusive
scl_oe  out  1  1 = pull SCL low
sda_oe  out  1  1 = pull SDA low
sda_in  in  1  SDA pin level, already synchronised externally

Behaviour:
- Reset values (reset=0 at a clk edge): scl_oe=0, sda_oe=0, busy=0, done0=done1=0, nack0=nack1=0, state=IDLE, last_grant=1.
- Reset mid-frame: the bus is released on the next edge and the frame is abandoned with no done pulse. Slaves recover on the next START.
- Quarter tick: a divider counts 0..CLK_DIV-1 and ticks at CLK_DIV-1. The divider clears on grant.
- Arbitration (IDLE only):
  - Exactly one req high: grant it.
  - Both high: grant the requester that is not last_grant.
  - On grant: latch adr/dat/owner, update last_grant, set busy=1.
  - adr/dat changes after the grant cycle are ignored.
- States and quarters (each quarter lasts CLK_DIV clks):
  - START: q0 both released; q1 sda_oe=1 (SDA falls while SCL high); q2 hold; q3 scl_oe=1.
  - BIT: 18 slots in order: address bits [6:0], W=0, ACK, data bits [7:0], ACK.
    - q0: sda_oe = ~bit, or 0 in ACK slots.
    - q1: scl_oe=0.
    - q2: sample sda_in in ACK slots.
    - q3: scl_oe=1.
  - ACK decisions:
    - Address ACK sampled 1: set nack and skip the data byte; go to STOP.
    - Data ACK sampled 1: set nack; continue to STOP.
  - STOP: q0 sda_oe=1; q1 scl_oe=0; q2 sda_oe=0 (SDA rises while SCL high); q3 idle bus time.
  - DONE: one clk. Pulse done<owner> and drive nack<owner>, then IDLE, busy=0.
- Latency from grant to done pulse:
  - Full transaction: 80*CLK_DIV+1 clks.
  - Address NACK: 44*CLK_DIV+1 clks.
- A requester whose req stays high after done is re-arbitrated on the next IDLE cycle. A minimum of one IDLE clk separates transactions.
- nackN is 0 whenever doneN is 0.
- Clock stretching is not supported; SCL is never sampled.

Optional Feature:
I2C_WR_RETRY_EN:
- Defined: after a NACK, the master completes STOP, then reissues START for the same latched operands. This repeats up to RETRIES extra times. done pulses only after success (nack=0) or after the last failed attempt (nack=1). busy stays high throughout.
- Undefined: exactly one attempt per grant; the RETRIES parameter is ignored.

Test Plan:
1. CLK_DIV=4, req0 with adr0=0x20, dat0=0xA5, slave model ACKs -> SDA bytes 0x40 then 0xA5 sampled at SCL rises; done0 at 321 clks after grant; nack0=0; slave IOout=0xA5.
2. req0 with adr0=0x27, no slave at that address -> STOP follows address ACK; done0 at 177 clks; nack0=1; no data bits clocked.
3. req0 and req1 both asserted in the first cycle after reset -> requester 0 served first, then requester 1; last_grant alternates while both remain high; one IDLE clk between frames.
4. reset=0 during data bit 3 -> on the next edge scl_oe=0, sda_oe=0, busy=0; no done pulse; next request produces a correct full frame.
5. dat0 changed from 0x5A to 0xFF one clk after grant -> wire carries 0x5A.
6. With I2C_WR_RETRY_EN, RETRIES=2, slave NACKs the first address phase then ACKs -> two START conditions observed; single done0; nack0=0.

Source files
------------

// File: rtl/i2c_expander_write_master.sv
// Single-byte open-drain I2C write master for PCF8574-style expanders, shared by two round-robin requesters.
// Optional macro I2C_WR_RETRY_EN: after a NACK, STOP then replay the frame up to RETRIES extra times.
module i2c_expander_write_master #(
   parameter int CLK_DIV = 125,
   parameter int RETRIES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0,
   input  logic [6:0] adr0,
   input  logic [7:0] dat0,
   output logic       done0,
   output logic       nack0,
   input  logic       req1,
   input  logic [6:0] adr1,
   input  logic [7:0] dat1,
   output logic       done1,
   output logic       nack1,
   output logic       busy,
   output logic       scl_oe,
   output logic       sda_oe,
   input  logic       sda_in
);

   typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_STOP, S_DONE} state_t;

   localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

   if (CLK_DIV < 2 || CLK_DIV > 65535 || RETRIES < 0 || RETRIES > 255) begin : g_bad_param
      $error("i2c_expander_write_master: CLK_DIV or RETRIES out of range");
   end

   state_t      state_q, state_d;
   logic [15:0] div_q, div_d;
   logic [1:0]  qtr_q, qtr_d;
   logic [4:0]  slot_q, slot_d;
   logic [6:0]  adr_q, adr_d;
   logic [7:0]  dat_q, dat_d;
   logic        owner_q, owner_d;
   logic        last_grant_q, last_grant_d;
   logic        nack_q, nack_d;
   logic        busy_q, busy_d;
   logic        done0_q, done0_d, done1_q, done1_d;
   logic        nack0_q, nack0_d, nack1_q, nack1_d;
   logic        scl_oe_q, scl_oe_d, sda_oe_q, sda_oe_d;
   logic        tick, pick;
   logic [17:0] frame_d;
`ifdef I2C_WR_RETRY_EN
   logic [7:0]  retry_q, retry_d;
`endif

   assign tick = (div_q == DIV_LAST);

   // Next-state logic; the pin outputs are decoded from the position the FSM is about to enter
   always_comb begin
      state_d      = state_q;
      div_d        = div_q;
      qtr_d        = qtr_q;
      slot_d       = slot_q;
      adr_d        = adr_q;
      dat_d        = dat_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      nack_d       = nack_q;
      busy_d       = busy_q;
      done0_d      = 1'b0;
      done1_d      = 1'b0;
      nack0_d      = 1'b0;
      nack1_d      = 1'b0;
      pick         = 1'b0;
`ifdef I2C_WR_RETRY_EN
      retry_d      = retry_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            busy_d = 1'b0;
            div_d  = '0;
            if (!(done0_q || done1_q) && (req0 || req1)) begin
               pick         = (req0 && req1) ? ~last_grant_q : req1;
               state_d      = S_START;
               qtr_d        = 2'd0;
               slot_d       = 5'd0;
               nack_d       = 1'b0;
               owner_d      = pick;
               last_grant_d = pick;
               busy_d       = 1'b1;
               adr_d        = pick ? adr1 : adr0;
               dat_d        = pick ? dat1 : dat0;
`ifdef I2C_WR_RETRY_EN
               retry_d      = 8'(RETRIES);
`endif
            end
         end
         S_START, S_BIT, S_STOP: begin
            div_d = tick ? '0 : div_q + 16'd1;
            if (tick) begin
               qtr_d = qtr_q + 2'd1;
               if (state_q == S_BIT && qtr_q == 2'd2 && (slot_q == 5'd8 || slot_q == 5'd17) && sda_in) begin
                  nack_d = 1'b1;
               end
               if (qtr_q == 2'd3) begin
                  if (state_q == S_START) begin
                     state_d = S_BIT;
                     slot_d  = 5'd0;
                  end else if (state_q == S_BIT) begin
                     if (slot_q == 5'd17 || (slot_q == 5'd8 && nack_q)) begin
                        state_d = S_STOP;
                     end else begin
                        slot_d = slot_q + 5'd1;
                     end
                  end else begin
`ifdef I2C_WR_RETRY_EN
                     if (nack_q && retry_q != 8'd0) begin
                        state_d = S_START;
                        nack_d  = 1'b0;
                        retry_d = retry_q - 8'd1;
                     end else begin
                        state_d = S_DONE;
                     end
`else
                     state_d = S_DONE;
`endif
                  end
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            done0_d = ~owner_q;
            done1_d = owner_q;
            nack0_d = ~owner_q & nack_q;
            nack1_d = owner_q & nack_q;
         end
      endcase

      frame_d  = {adr_d, 1'b0, 1'b1, dat_d, 1'b1};
      scl_oe_d = 1'b0;
      sda_oe_d = 1'b0;
      unique case (state_d)
         S_START: begin
            scl_oe_d = (qtr_d == 2'd3);
            sda_oe_d = (qtr_d != 2'd0);
         end
         S_BIT: begin
            scl_oe_d = (qtr_d == 2'd0) || (qtr_d == 2'd3);
            sda_oe_d = ~frame_d[5'd17 - slot_d];
         end
         S_STOP: begin
            scl_oe_d = (qtr_d == 2'd0);
            sda_oe_d = (qtr_d <= 2'd1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         div_q        <= '0;
         qtr_q        <= 2'd0;
         slot_q       <= 5'd0;
         adr_q        <= '0;
         dat_q        <= '0;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         nack_q       <= 1'b0;
         busy_q       <= 1'b0;
         done0_q      <= 1'b0;
         done1_q      <= 1'b0;
         nack0_q      <= 1'b0;
         nack1_q      <= 1'b0;
         scl_oe_q     <= 1'b0;
         sda_oe_q     <= 1'b0;
`ifdef I2C_WR_RETRY_EN
         retry_q      <= '0;
`endif
      end else begin
         state_q      <= state_d;
         div_q        <= div_d;
         qtr_q        <= qtr_d;
         slot_q       <= slot_d;
         adr_q        <= adr_d;
         dat_q        <= dat_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         nack_q       <= nack_d;
         busy_q       <= busy_d;
         done0_q      <= done0_d;
         done1_q      <= done1_d;
         nack0_q      <= nack0_d;
         nack1_q      <= nack1_d;
         scl_oe_q     <= scl_oe_d;
         sda_oe_q     <= sda_oe_d;
`ifdef I2C_WR_RETRY_EN
         retry_q      <= retry_d;
`endif
      end
   end

   assign done0  = done0_q;
   assign done1  = done1_q;
   assign nack0  = nack0_q;
   assign nack1  = nack1_q;
   assign busy   = busy_q;
   assign scl_oe = scl_oe_q;
   assign sda_oe = sda_oe_q;

endmodule

// File: tb/tb_i2c_expander_write_master.sv
// Scoreboard bench for i2c_expander_write_master: open-drain bus with an expander slave model.
module tb_i2c_expander_write_master;

   localparam int CD = 4;
   localparam int RT = 2;
`ifdef I2C_WR_RETRY_EN
   localparam int MAXK = RT;
`else
   localparam int MAXK = 0;
`endif
   localparam int WAIT_MAX = 3000;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       req0 = 1'b0, req1 = 1'b0;
   logic [6:0] adr0 = '0, adr1 = '0;
   logic [7:0] dat0 = '0, dat1 = '0;
   logic       done0, done1, nack0, nack1, busy, scl_oe, sda_oe;
   logic       slave_sda_oe = 1'b0;
   logic       scl_line, sda_line;

   assign scl_line = ~scl_oe;
   assign sda_line = ~(sda_oe | slave_sda_oe);

   i2c_expander_write_master #(.CLK_DIV(CD), .RETRIES(RT)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .adr0(adr0), .dat0(dat0), .done0(done0), .nack0(nack0),
      .req1(req1), .adr1(adr1), .dat1(dat1), .done1(done1), .nack1(nack1),
      .busy(busy), .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_in(sda_line)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fails  = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic       owner;
      logic       nack;
      int         lat;
      logic [7:0] adr_byte;
      logic [7:0] dat;
      int         starts;
      int         rises;
   } exp_t;

   exp_t sb[$];
   logic model_last = 1'b1;
   int   flaky_arms = 0;

   task automatic checkOutput(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, req, cyc);
      end
   endtask

   // Expander population on the bus: the set that answers, plus 0x30 which refuses its first address phase
   function automatic logic inAckSet(input logic [6:0] a);
      return (a >= 7'h20 && a <= 7'h23) || (a >= 7'h38 && a <= 7'h3B);
   endfunction

   function automatic exp_t predict(input logic owner, input logic [6:0] a, input logic [7:0] d);
      exp_t e;
      logic aok;
      e.owner = owner; e.adr_byte = {a, 1'b0}; e.dat = d;
      e.lat = 1; e.starts = 0; e.nack = 1'b1; e.rises = 0;
      for (int k = 0; k <= MAXK; k++) begin
         aok = inAckSet(a) || (a == 7'h30 && k > 0);
         e.starts++;
         if (!aok) begin
            e.lat += 44 * CD; e.rises = 10; e.nack = 1'b1;
         end else begin
            e.lat += 80 * CD; e.rises = 19; e.nack = (d == 8'hEE);
         end
         if (!e.nack) break;
      end
      return e;
   endfunction

   // Bus watcher and expander slave share one process so every bus variable has a single writer
   logic       bits [0:31];
   int         rise_cnt = 0, start_cnt = 0, bcnt = 0, flaky_used = 0;
   logic       in_frame = 1'b0, phase = 1'b0, scl_prev = 1'b1, sda_prev = 1'b1;
   logic [7:0] sh = '0;
   logic [6:0] sl_adr = '0;
   logic [7:0] io_mem [0:127];

   always @(scl_line or sda_line) begin
      if (scl_line === 1'b1 && scl_prev === 1'b1 && sda_prev === 1'b1 && sda_line === 1'b0) begin
         start_cnt++; rise_cnt = 0; in_frame = 1'b1; bcnt = 0; phase = 1'b0; slave_sda_oe = 1'b0;
      end else if (scl_line === 1'b1 && scl_prev === 1'b1 && sda_prev === 1'b0 && sda_line === 1'b1) begin
         in_frame = 1'b0; slave_sda_oe = 1'b0;
      end else if (scl_prev === 1'b0 && scl_line === 1'b1) begin
         if (rise_cnt < 32) bits[rise_cnt] = sda_line;
         rise_cnt++;
         if (in_frame && bcnt < 9) begin
            if (bcnt < 8) sh = {sh[6:0], sda_line};
            bcnt++;
         end
      end else if (scl_prev === 1'b1 && scl_line === 1'b0 && in_frame) begin
         if (bcnt == 8) begin
            if (!phase) begin
               sl_adr = sh[7:1];
               if (sh[0] == 1'b0 && (inAckSet(sh[7:1]) || (sh[7:1] == 7'h30 && flaky_arms <= flaky_used)))
                  slave_sda_oe = 1'b1;
               else begin
                  if (sh[7:1] == 7'h30) flaky_used++;
                  in_frame = 1'b0;
               end
            end else if (sh != 8'hEE) begin
               io_mem[sl_adr] = sh;
               slave_sda_oe = 1'b1;
            end
         end else if (bcnt == 9) begin
            slave_sda_oe = 1'b0; bcnt = 0;
            if (phase) in_frame = 1'b0;
            phase = 1'b1;
         end
      end
      scl_prev = scl_line;
      sda_prev = sda_line;
   end

   function automatic logic [7:0] wireByte(input int base);
      logic [7:0] b = '0;
      for (int i = 0; i < 8; i++) b = {b[6:0], bits[base + i]};
      return b;
   endfunction

   // Monitor: pops the scoreboard whenever a done pulse is presented
   int   grant_cyc = 0, start_base = 0;
   logic busy_prev = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         if (busy && !busy_prev) begin
            grant_cyc = cyc; start_base = start_cnt;
         end
         if (!done0 && !done1) checkOutput("nack_without_done", {30'd0, nack1, nack0}, 0);
         if (done0 || done1) begin
            if (sb.size() == 0) begin
               n_checks++; n_fails++;
               $display("[TB] FAIL unexpected_done: done0=%0b done1=%0b with empty scoreboard", done0, done1);
            end else begin
               e = sb.pop_front();
               checkOutput("done_both", {31'd0, done0 & done1}, 0);
               checkOutput("done_owner", {31'd0, done1}, {31'd0, e.owner});
               checkOutput("nack", {31'd0, e.owner ? nack1 : nack0}, {31'd0, e.nack});
               checkOutput("latency", cyc - grant_cyc, e.lat);
               checkOutput("start_count", start_cnt - start_base, e.starts);
               checkOutput("scl_rises", rise_cnt, e.rises);
               checkOutput("wire_addr_byte", {24'd0, wireByte(0)}, {24'd0, e.adr_byte});
               if (e.rises == 19) checkOutput("wire_data_byte", {24'd0, wireByte(9)}, {24'd0, e.dat});
               if (!e.nack) checkOutput("slave_ioout", {24'd0, io_mem[e.adr_byte[7:1]]}, {24'd0, e.dat});
            end
         end
      end
      busy_prev = busy;
   end

   task automatic applyReset();
      @(negedge clk);
      reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_scl_oe", {31'd0, scl_oe}, 0);
      checkOutput("reset_sda_oe", {31'd0, sda_oe}, 0);
      checkOutput("reset_busy", {31'd0, busy}, 0);
      checkOutput("reset_done0", {31'd0, done0}, 0);
      checkOutput("reset_done1", {31'd0, done1}, 0);
      checkOutput("reset_nack0", {31'd0, nack0}, 0);
      checkOutput("reset_nack1", {31'd0, nack1}, 0);
      sb.delete();
      model_last = 1'b1;
      reset = 1'b1;
   endtask

   task automatic applyStimulus(input logic owner, input logic [6:0] a, input logic [7:0] d);
      int t;
      sb.push_back(predict(owner, a, d));
      model_last = owner;
      if (a == 7'h30) flaky_arms++;
      @(negedge clk);
      if (owner) begin req1 = 1'b1; adr1 = a; dat1 = d; end
      else       begin req0 = 1'b1; adr0 = a; dat0 = d; end
      t = 0;
      while (!busy && t < 50) begin @(negedge clk); t++; end
      if (!busy) begin
         n_checks++; n_fails++;
         $display("[TB] FAIL grant_timeout: busy=0 after %0d cycles, required 1", t);
         req0 = 1'b0; req1 = 1'b0; sb.delete();
         return;
      end
      @(negedge clk);
      if (owner) begin adr1 = ~a; dat1 = (d == 8'hFF) ? 8'h00 : 8'hFF; end
      else       begin adr0 = ~a; dat0 = (d == 8'hFF) ? 8'h00 : 8'hFF; end
      t = 0;
      while (!(owner ? done1 : done0) && t < WAIT_MAX) begin @(negedge clk); t++; end
      if (t >= WAIT_MAX) begin
         n_checks++; n_fails++;
         $display("[TB] FAIL done_timeout: no done after %0d cycles, required a done pulse", t);
         sb.delete();
      end
      req0 = 1'b0; req1 = 1'b0;
   endtask

   // Both requesters held high for n frames: grants must alternate with one idle clk between
   task automatic applyPair(input int n);
      logic       who;
      logic [7:0] d0, d1;
      int         t, dc;
      d0 = 8'($urandom); d1 = 8'($urandom);
      if (d0 == 8'hEE) d0 = 8'h11;
      if (d1 == 8'hEE) d1 = 8'h12;
      who = ~model_last;
      for (int k = 0; k < n; k++) begin
         sb.push_back(predict(who, who ? 7'h22 : 7'h21, who ? d1 : d0));
         model_last = who;
         who = ~who;
      end
      req0 = 1'b1; adr0 = 7'h21; dat0 = d0;
      req1 = 1'b1; adr1 = 7'h22; dat1 = d1;
      for (int k = 0; k < n; k++) begin
         t = 0;
         while (!(done0 || done1) && t < WAIT_MAX) begin @(negedge clk); t++; end
         if (t >= WAIT_MAX) begin
            n_checks++; n_fails++;
            $display("[TB] FAIL pair_timeout: no done after %0d cycles, required a done pulse", t);
            sb.delete();
            break;
         end
         dc = cyc;
         if (k == n - 1) break;
         @(negedge clk);
         t = 0;
         while (!busy && t < 10) begin @(negedge clk); t++; end
         checkOutput("idle_gap", cyc - dc, 2);
      end
      req0 = 1'b0; req1 = 1'b0;
   endtask

   task automatic abortMidFrame(input logic [6:0] a, input logic [7:0] d);
      int t;
      @(negedge clk);
      req0 = 1'b1; adr0 = a; dat0 = d;
      t = 0;
      while (!busy && t < 50) begin @(negedge clk); t++; end
      repeat ((4 + 4 * 13 + 1) * CD) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("abort_scl_oe", {31'd0, scl_oe}, 0);
      checkOutput("abort_sda_oe", {31'd0, sda_oe}, 0);
      checkOutput("abort_busy", {31'd0, busy}, 0);
      req0 = 1'b0;
      repeat (3) @(negedge clk);
      model_last = 1'b1;
      reset = 1'b1;
   endtask

   logic [6:0] adr_pool [0:8];

   initial begin
      logic [7:0] d;
      adr_pool = '{7'h20, 7'h21, 7'h22, 7'h23, 7'h38, 7'h3B, 7'h27, 7'h55, 7'h30};
      applyReset();
      applyStimulus(1'b0, 7'h20, 8'hA5);
      applyStimulus(1'b0, 7'h27, 8'h3C);
      applyStimulus(1'b1, 7'h30, 8'h77);
      applyStimulus(1'b0, 7'h22, 8'hEE);
      applyReset();
      applyPair(4);
      abortMidFrame(7'h21, 8'hC3);
      applyStimulus(1'b0, 7'h21, 8'h5A);
      for (int i = 0; i < 16; i++) begin
         d = 8'($urandom);
         if ($urandom_range(0, 7) == 0) d = 8'hEE;
         applyStimulus(1'($urandom_range(0, 1)), adr_pool[$urandom_range(0, 8)], d);
      end
      repeat (5) @(negedge clk);
      checkOutput("scoreboard_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #900000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
